// File: rtl/wb_burst_reader.sv
// Wishbone read-burst master that fetches a block of words into a FWFT output FIFO.
// Define WB_READER_CLASSIC_EN to fetch each word with its own classic single cycle instead.
module wb_burst_reader #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          base_adr,
  input  logic [CNT_WIDTH-1:0] nwords,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 cyc,
  output logic                 stb,
  output logic                 we,
  output logic [31:0]          adr,
  output logic [3:0]           sel,
  output logic [2:0]           cti,
  output logic [1:0]           bte,
  input  logic                 ack,
  input  logic                 err,
  input  logic [31:0]          dat_sm,
  output logic                 out_valid,
  output logic [31:0]          out_data,
  input  logic                 out_ready
);
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, DONE} state_t;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] remaining_reg;
  logic [BW-1:0]        beats_left_reg;
  logic [BW-1:0]        len;
  logic [CW-1:0]        free_slots;
  logic                 space_ok;

  logic [31:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 push_req;
  logic                 do_push;
  logic                 do_pop;

  assign we  = 1'b0;
  assign sel = 4'hF;
  assign bte = 2'b00;

  function automatic logic [2:0] beat_cti(input logic [BW-1:0] beats);
`ifdef WB_READER_CLASSIC_EN
    return 3'b000;
`else
    return (beats > BW'(1)) ? 3'b010 : 3'b111;
`endif
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
`ifdef WB_READER_CLASSIC_EN
    len = BW'(1);
`else
    if (remaining_reg < CNT_WIDTH'(BURST_LEN))
      len = remaining_reg[BW-1:0];
    else
      len = BW'(BURST_LEN);
`endif
  end

  // Nothing is in flight outside BURST, so free space alone decides whether a burst fits.
  assign free_slots = CW'(FIFO_DEPTH) - count_reg;
  assign space_ok   = free_slots >= CW'(len);

  assign push_req  = (state_reg == BURST) && stb && ack && !err;
  assign do_pop    = out_valid && out_ready;
  assign do_push   = push_req && ((count_reg != CW'(FIFO_DEPTH)) || do_pop);
  assign out_valid = (count_reg != '0);
  assign out_data  = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push)
      fifo_mem[wr_ptr_reg] <= dat_sm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)
        count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push)
        count_reg <= count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      remaining_reg  <= '0;
      beats_left_reg <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cyc            <= 1'b0;
      stb            <= 1'b0;
      adr            <= '0;
      cti            <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (nwords != '0) begin
              adr           <= {base_adr[31:2], 2'b00};
              remaining_reg <= nwords;
              error         <= 1'b0;
              busy          <= 1'b1;
              state_reg     <= WAIT_SPACE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            cyc            <= 1'b1;
            stb            <= 1'b1;
            cti            <= beat_cti(len);
            beats_left_reg <= len;
            state_reg      <= BURST;
          end
        end
        BURST: begin
          if (stb && err) begin
            cyc       <= 1'b0;
            stb       <= 1'b0;
            cti       <= 3'b000;
            error     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (stb && ack) begin
            adr            <= adr + 32'd4;
            remaining_reg  <= remaining_reg - CNT_WIDTH'(1);
            beats_left_reg <= beats_left_reg - BW'(1);
            if (beats_left_reg == BW'(1)) begin
              cyc <= 1'b0;
              stb <= 1'b0;
              cti <= 3'b000;
              if (remaining_reg == CNT_WIDTH'(1)) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                state_reg <= DONE;
              end else begin
                state_reg <= WAIT_SPACE;
              end
            end else begin
              cti <= beat_cti(beats_left_reg - BW'(1));
            end
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: Wishbone slave model with memory, a block-level
// reference model of the expected bus beats and output stream, table rows and random blocks.
module tb_wb_burst_reader;
  localparam int BL  = 8;
  localparam int FD  = 16;
  localparam int CNW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [31:0]    base_adr;
  logic [CNW-1:0] nwords;
  logic           busy, done, error, cyc, stb, we;
  logic [31:0]    adr;
  logic [3:0]     sel;
  logic [2:0]     cti;
  logic [1:0]     bte;
  logic           ack, err;
  logic [31:0]    dat_sm;
  logic           out_valid;
  logic [31:0]    out_data;
  logic           out_ready;

  wb_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .CNT_WIDTH(CNW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .nwords(nwords),
    .busy(busy), .done(done), .error(error), .cyc(cyc), .stb(stb), .we(we),
    .adr(adr), .sel(sel), .cti(cti), .bte(bte), .ack(ack), .err(err),
    .dat_sm(dat_sm), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
  } bus_t;

  typedef struct {
    logic [31:0] base;
    int          n;
    int          lat;
    int          ws;
    int          eb;
    int          rmode;
    int          words;
    logic        err;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [1024];
  bus_t        exp_bus_q[$];
  logic [31:0] exp_data_q[$];
  int          first_lat = 0, beat_ws = 0, err_beat = 0, beat_no = 0;
  int          ready_mode = 0;
  int          ack_count = 0, out_words = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_cti(input int j, input int len);
`ifdef WB_READER_CLASSIC_EN
    return 3'b000;
`else
    return (j == len - 1) ? 3'b111 : 3'b010;
`endif
  endfunction

  // Slave: first beat of a cycle after first_lat idle cycles, later beats after beat_ws.
  initial begin
    int wcnt, need;
    bit fresh;
    ack = 1'b0; err = 1'b0; dat_sm = '0; wcnt = 0; fresh = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst || !(cyc && stb)) begin
        ack = 1'b0; err = 1'b0; wcnt = 0; fresh = 1'b1;
      end else begin
        if (ack) begin fresh = 1'b0; wcnt = 0; end
        need = fresh ? first_lat : beat_ws;
        if (wcnt >= need) begin
          beat_no++;
          if (beat_no == err_beat) begin err = 1'b1; ack = 1'b0; end
          else begin ack = 1'b1; err = 1'b0; dat_sm = mem[(adr >> 2) & 32'h3FF]; end
        end else begin
          ack = 1'b0; err = 1'b0; wcnt++;
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Bus and stream monitors, sampled on the falling edge.
  initial begin
    bus_t        b;
    bit          prev_pending;
    logic [31:0] prev_adr, w;
    logic [2:0]  prev_cti;
    prev_pending = 1'b0; prev_adr = '0; prev_cti = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cyc && stb && ack && !err) begin
          ack_count++;
          if (exp_bus_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL bus_extra: beat at adr %h, none expected", adr);
          end else begin
            b = exp_bus_q.pop_front();
            check("bus_adr", adr, b.adr);
            check("bus_cti", 32'(cti), 32'(b.cti));
          end
        end
        if (prev_pending) begin
          check("stb_hold", 32'(stb), 32'd1);
          check("adr_hold", adr, prev_adr);
          check("cti_hold", 32'(cti), 32'(prev_cti));
        end
        prev_pending = cyc && stb && !ack && !err;
        prev_adr = adr; prev_cti = cti;
        if (out_valid && out_ready) begin
          out_words++;
          if (exp_data_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out_extra: word %h, none expected", out_data);
          end else begin
            w = exp_data_q.pop_front();
            check("out_data", out_data, w);
          end
        end
      end else begin
        prev_pending = 1'b0;
      end
    end
  end

  task automatic begin_block(input logic [31:0] base, input int n, input int lat,
                             input int ws, input int eb, input int rmode);
    int   rem, len, idx, nb;
    bus_t b;
    exp_bus_q.delete(); exp_data_q.delete();
    nb  = (eb != 0) ? eb - 1 : n;
    idx = 0; rem = n;
    while (rem > 0) begin
      len = (rem < BL) ? rem : BL;
      for (int j = 0; j < len; j++) begin
        if (idx < nb) begin
          b.adr = (base & ~32'h3) + 32'(4 * idx);
          b.cti = model_cti(j, len);
          exp_bus_q.push_back(b);
          exp_data_q.push_back(mem[(b.adr >> 2) & 32'h3FF]);
        end
        idx++;
      end
      rem -= len;
    end
    first_lat = lat; beat_ws = ws; err_beat = eb; beat_no = 0;
    ready_mode = rmode; ack_count = 0; out_words = 0;
    base_adr = base; nwords = CNW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_clear", 32'(error), 32'd0);
    check("busy_set", 32'(busy), 32'd1);
  endtask

  task automatic finish_block(input int exp_words, input logic exp_err);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("busy_at_done", 32'(busy), 32'd0);
      check("cyc_at_done", 32'(cyc), 32'd0);
      check("error_flag", 32'(error), 32'(exp_err));
      @(negedge clk);
      check("done_once", 32'(done), 32'd0);
    end
    if (ready_mode == 0) ready_mode = 1;
    for (int t = 0; t < 3000 && exp_data_q.size() > 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drained", 32'(exp_data_q.size()), 32'd0);
    check("words", 32'(out_words), 32'(exp_words));
    check("bus_left", 32'(exp_bus_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   n, eb;
    bit   got;
    vecs[0] = '{32'h0000_0100,  8, 1, 0, 0, 1,  8, 1'b0};
    vecs[1] = '{32'h0000_0200, 19, 1, 0, 0, 1, 19, 1'b0};
    vecs[2] = '{32'h0000_0300, 10, 2, 2, 0, 1, 10, 1'b0};
    vecs[3] = '{32'h0000_0400,  8, 1, 0, 3, 1,  2, 1'b1};
    vecs[4] = '{32'h0000_0500,  5, 0, 0, 0, 2,  5, 1'b0};
    vecs[5] = '{32'h0000_07F3, 12, 1, 1, 0, 2, 12, 1'b0};
    vecs[6] = '{32'hFFFF_FFF8,  4, 1, 0, 0, 1,  4, 1'b0};
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    rst = 1'b1; start = 1'b0; base_adr = '0; nwords = '0;
    repeat (3) @(negedge clk);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cti", 32'(cti), 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("tie_we", 32'(we), 32'd0);
    check("tie_sel", 32'(sel), 32'hF);
    check("tie_bte", 32'(bte), 32'd0);
    rst = 1'b0; mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      begin_block(vecs[i].base, vecs[i].n, vecs[i].lat, vecs[i].ws, vecs[i].eb, vecs[i].rmode);
      finish_block(vecs[i].words, vecs[i].err);
      $display("vec %0d: base %h n %0d -> %0d words, error %0b", i, vecs[i].base, vecs[i].n,
               out_words, error);
    end

    // FIFO full: two bursts fit, then the block parks with cyc low; a start while busy is ignored.
    begin_block(32'h0000_1000, 40, 1, 0, 0, 0);
    repeat (150) @(negedge clk);
    check("stall_acks", 32'(ack_count), 32'd16);
    check("stall_cyc", 32'(cyc), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    base_adr = '0; nwords = CNW'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    ready_mode = 1;
    finish_block(40, 1'b0);
    $display("stall: 40 words requested -> %0d words", out_words);

    // Reset mid-burst.
    begin_block(32'h0000_0800, 16, 1, 0, 0, 1);
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (ack_count >= 3) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_mid_reached", 32'(got), 32'd1);
    mon_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cyc", 32'(cyc), 32'd0);
    check("rst_mid_stb", 32'(stb), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; exp_bus_q.delete(); exp_data_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    $display("reset mid-burst after %0d beats", ack_count);

    // Zero-length request: a lone done pulse and no bus activity.
    base_adr = 32'h40; nwords = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_cyc", 32'(cyc), 32'd0);
    @(negedge clk);
    check("zero_done_once", 32'(done), 32'd0);
    check("zero_cyc2", 32'(cyc), 32'd0);
    $display("zero-length start: done pulse only");

    for (int r = 0; r < 15; r++) begin
      n  = $urandom_range(1, 50);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      begin_block($urandom, n, $urandom_range(0, 2), $urandom_range(0, 2), eb, 2);
      finish_block((eb != 0) ? eb - 1 : n, eb != 0);
      $display("rand %0d: n %0d err_beat %0d -> %0d words", r, n, eb, out_words);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_burst_reader.md
Name: wb_burst_reader

Overview:
- Wishbone master that fetches a block of 32-bit words from a Wishbone slave (the on-chip BlockRAM or the memory controller) using incrementing read bursts.
- Pushes the fetched words into an internal FIFO, which presents them as a valid/ready stream to a downstream consumer (e.g. a pixel pipeline).
- Sits directly upstream of the memory slave on the same bus and uses the same clock domain.

Parameters:
- BURST_LEN, 8: max beats per burst, power of 2, range 1..16.
- FIFO_DEPTH, 16: output FIFO depth in words, power of 2, must be >= BURST_LEN.
- CNT_WIDTH, 16: width of the word-count input.

Ports:
- clk  in  1  system clock; also the Wishbone clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- base_adr  in  32  byte address of the first word; bits [1:0] ignored and forced to 0.
- nwords  in  CNT_WIDTH  number of words to fetch; 0 means nothing to fetch.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the block ends (normally or on error).
- error  out  1  sticky; set by wb_err, cleared by the next accepted start.
- cyc  out  1  Wishbone cyc.
- stb  out  1  Wishbone stb.
- we  out  1  Wishbone we; tied to 0.
- adr  out  32  Wishbone byte address.
- sel  out  4  Wishbone sel; tied to 4'hF.
- cti  out  3  Wishbone cycle type.
- bte  out  2  Wishbone burst type; tied to 2'b00 (linear).
- ack  in  1  Wishbone ack.
- err  in  1  Wishbone err.
- dat_sm  in  32  read data from the slave.
- out_valid  out  1  FIFO not empty.
- out_data  out  32  FIFO head word; first-word-fall-through.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.

Behaviour:
- Reset: all of the following go to 0: cyc, stb, busy, done, error, cti, adr, out_valid, FIFO pointers, counters. State goes to IDLE.
- Reset mid-burst drops cyc/stb in the next cycle and discards FIFO contents.
- States:
  - IDLE: start with nwords != 0 latches adr = base_adr & ~3 and remaining = nwords, clears error, sets busy, goes to WAIT_SPACE. start with nwords == 0 pulses done for one cycle, stays in IDLE, leaves busy at 0.
  - WAIT_SPACE: computes len = min(BURST_LEN, remaining). Goes to BURST when FIFO free slots minus words in flight is >= len. Data is therefore never dropped and ack is never ignored.
  - BURST: cyc = stb = 1. cti = 3'b010 while beats_left > 1 and 3'b111 on the last beat (a len = 1 burst issues 3'b111 only).
    - Each cycle with ack: push dat_sm into the FIFO, adr += 4, decrement beats_left and remaining.
    - After the last-beat ack: cyc/stb fall in the next cycle. If remaining == 0, go to DONE; otherwise go to WAIT_SPACE.
    - adr, cti and stb are held stable while ack is low (wait states are allowed).
  - DONE: done = 1 for one cycle, busy falls, returns to IDLE. The FIFO may still hold data; drain continues independently.
- err while in BURST: the word is not pushed. cyc/stb drop next cycle, error is set, and the state goes to DONE. Remaining words are abandoned.
- start while busy is ignored.
- FIFO: same-cycle push and pop is allowed when full or empty. count is exact; it never overflows or underflows. Pointers wrap modulo FIFO_DEPTH.
- Arithmetic: adr wraps modulo 2^32. remaining is CNT_WIDTH bits, beats_left is clog2(BURST_LEN)+1 bits.
- Bursts are not split at any address boundary.
- ack with stb low is ignored.

Optional Feature:
- Macro WB_READER_CLASSIC_EN.
- When defined: every word is a separate classic cycle.
  - cti = 3'b000 and len is forced to 1.
  - stb (and cyc) deassert for exactly one cycle after each ack before the next request.
  - WAIT_SPACE needs only one free slot.
- When undefined: burst behaviour as above. Classic mode is unreachable.
- Ports and all other behaviour are identical in both builds.

Test Plan:
- base_adr = 0x100, nwords = 8, slave acks every cycle after a 1-cycle latency, out_ready = 1 → one burst with cti 010 x7 then 111; adr runs 0x100..0x11C; out_data sequence equals mem[0x40..0x47]; done pulses once; busy falls with it.
- nwords = 19, BURST_LEN = 8 → bursts of 8, 8, 3; the third burst ends with cti = 111 on adr base+0x48; exactly 19 words are output.
- out_ready = 0, nwords = 40, FIFO_DEPTH = 16 → exactly two bursts complete, then the block waits in WAIT_SPACE with cyc = 0. Asserting out_ready resumes fetching; all 40 words arrive in order with no loss.
- Slave inserts 2 wait states per beat → adr/cti/stb stay stable while ack = 0; data order is correct.
- err asserted on the 3rd beat → 2 words are output, error = 1, done pulses, cyc = 0 next cycle. A new start clears error.
- rst asserted mid-burst → next cycle cyc = stb = busy = out_valid = 0. A start with nwords = 0 gives a done pulse with no bus activity. With WB_READER_CLASSIC_EN, nwords = 3 → three cti = 000 cycles separated by one idle stb cycle.
